// File: rtl/rx_sync_ctrl_if.sv
// Sample stream bundle for rx_sync_ctrl.
//   sample_in_i/q, sample_in_valid    : raw rx samples and qualifier (source -> controller)
//   sample_out_i/q, sample_out_valid  : registered samples, valid gated to RECEIVE
// The master modport is the sample source / sink side; slave is the controller.
interface rx_sync_ctrl_if #(
  parameter int unsigned DW = 16
);
  logic signed [DW-1:0] sample_in_i;
  logic signed [DW-1:0] sample_in_q;
  logic                 sample_in_valid;
  logic signed [DW-1:0] sample_out_i;
  logic signed [DW-1:0] sample_out_q;
  logic                 sample_out_valid;

  modport master (
    output sample_in_i,
    output sample_in_q,
    output sample_in_valid,
    input  sample_out_i,
    input  sample_out_q,
    input  sample_out_valid
  );

  modport slave (
    input  sample_in_i,
    input  sample_in_q,
    input  sample_in_valid,
    output sample_out_i,
    output sample_out_q,
    output sample_out_valid
  );
endinterface

// File: rtl/rx_sync_ctrl.sv
// rx_sync_ctrl: acquisition sequencer for the 802.11a receive path.
//   IDLE -> DETECT_STS -> DETECT_LTS -> RECEIVE -> HOLDOFF -> DETECT_STS ...
// Gates the packet detector, the LTS align / fine-CFO stage and the data stage, applies
// LTS and packet-length timeouts, reports fail codes and registers the sample stream.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   enable                         0 forces IDLE on the next cycle
//   smp (rx_sync_ctrl_if.slave)    sample input and gated, registered sample output
//   sts_coarse_freq_offset_valid   STS found pulse
//   detect_lts_status_valid/status LTS search result (status 1 = error)
//   pkt_done                       decoder end-of-packet pulse
//   sts/lts_detect_enable, rx_data_enable  state decodes
//   state_o                        0 IDLE, 1 DETECT_STS, 2 DETECT_LTS, 3 RECEIVE, 4 HOLDOFF
//   sample_cnt                     valid samples since STS detect (saturating)
//   sync_ok, sync_fail             1-cycle event pulses
//   fail_code                      01 LTS timeout, 10 LTS error, 11 overlength (sticky)
// Optional build macro RX_SYNC_STATS_EN adds stats_clr and the ok_cnt, lts_err_cnt,
// timeout_cnt saturating event counters.
module rx_sync_ctrl #(
  parameter int unsigned DW          = 16,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned LTS_TIMEOUT = 320,
  parameter int unsigned MAX_PKT     = 40000,
  parameter int unsigned HOLDOFF     = 16
`ifdef RX_SYNC_STATS_EN
  ,
  parameter int unsigned STAT_W      = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  rx_sync_ctrl_if.slave    smp,
  input  logic             sts_coarse_freq_offset_valid,
  input  logic             detect_lts_status_valid,
  input  logic             detect_lts_status,
  input  logic             pkt_done,
  output logic             sts_detect_enable,
  output logic             lts_detect_enable,
  output logic             rx_data_enable,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             sync_ok,
  output logic             sync_fail,
  output logic [1:0]       fail_code
`ifdef RX_SYNC_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [STAT_W-1:0] ok_cnt,
  output logic [STAT_W-1:0] lts_err_cnt,
  output logic [STAT_W-1:0] timeout_cnt
`endif
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StDetectSts = 3'd1,
    StDetectLts = 3'd2,
    StReceive   = 3'd3,
    StHoldoff   = 3'd4
  } state_e;

  localparam logic [1:0] FailTimeout = 2'b01;
  localparam logic [1:0] FailLtsErr  = 2'b10;
  localparam logic [1:0] FailOverlen = 2'b11;

  // Limits widened by one bit so the compare against timer+1 cannot wrap.
  localparam logic [CNT_W:0] LtsLim  = (CNT_W+1)'(LTS_TIMEOUT);
  localparam logic [CNT_W:0] PktLim  = (CNT_W+1)'(MAX_PKT);
  localparam logic [CNT_W:0] HoldLim = (CNT_W+1)'(HOLDOFF);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ok_q, ok_d;
  logic             fail_q, fail_d;
  logic [1:0]       code_q, code_d;
  logic [DW-1:0]    out_i_q, out_q_q;
  logic             out_valid_q;

  logic [CNT_W:0]   timer_inc;
  logic             lts_hit, pkt_hit, hold_hit;
  logic             vld;

  assign vld       = smp.sample_in_valid;
  assign timer_inc = {1'b0, timer_q} + 1'b1;
  // A limit is reached on the valid sample that brings the count up to it.
  assign lts_hit   = vld && (timer_inc >= LtsLim);
  assign pkt_hit   = vld && (timer_inc >= PktLim);
  assign hold_hit  = (HOLDOFF == 0) || (vld && (timer_inc >= HoldLim));

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    ok_d    = 1'b0;
    fail_d  = 1'b0;
    code_d  = code_q;

    unique case (state_q)
      StIdle: begin
        state_d = StDetectSts;
      end
      StDetectSts: begin
        if (sts_coarse_freq_offset_valid) begin
          state_d = StDetectLts;
          cnt_d   = '0;
        end
      end
      StDetectLts: begin
        if (vld && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        // A status report takes priority over a coincident timeout.
        if (detect_lts_status_valid) begin
          if (detect_lts_status) begin
            state_d = StHoldoff;
            fail_d  = 1'b1;
            code_d  = FailLtsErr;
          end else begin
            state_d = StReceive;
            ok_d    = 1'b1;
          end
        end else if (lts_hit) begin
          state_d = StHoldoff;
          fail_d  = 1'b1;
          code_d  = FailTimeout;
        end
      end
      StReceive: begin
        if (vld && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        // A packet that ends exactly on the length limit is still good.
        if (pkt_done) begin
          state_d = StHoldoff;
        end else if (pkt_hit) begin
          state_d = StHoldoff;
          fail_d  = 1'b1;
          code_d  = FailOverlen;
        end
      end
      StHoldoff: begin
        if (hold_hit) state_d = StDetectSts;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // One shared timer, restarted on every state change.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (vld && (state_q inside {StDetectLts, StReceive, StHoldoff})) begin
      timer_d = timer_inc[CNT_W-1:0];
    end

    // Disable aborts silently but leaves the last fail code visible.
    if (!enable) begin
      state_d = StIdle;
      timer_d = '0;
      cnt_d   = '0;
      ok_d    = 1'b0;
      fail_d  = 1'b0;
      code_d  = code_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      cnt_q       <= '0;
      ok_q        <= 1'b0;
      fail_q      <= 1'b0;
      code_q      <= 2'b00;
      out_i_q     <= '0;
      out_q_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      ok_q        <= ok_d;
      fail_q      <= fail_d;
      code_q      <= code_d;
      out_i_q     <= smp.sample_in_i;
      out_q_q     <= smp.sample_in_q;
      // Gating with enable keeps the last RECEIVE sample from leaking out on an abort.
      out_valid_q <= vld && rx_data_enable && enable;
    end
  end

  assign sts_detect_enable    = (state_q == StDetectSts);
  assign lts_detect_enable    = (state_q == StDetectLts);
  assign rx_data_enable       = (state_q == StReceive);
  assign state_o              = state_q;
  assign sample_cnt           = cnt_q;
  assign sync_ok              = ok_q;
  assign sync_fail            = fail_q;
  assign fail_code            = code_q;
  assign smp.sample_out_i     = out_i_q;
  assign smp.sample_out_q     = out_q_q;
  assign smp.sample_out_valid = out_valid_q;

`ifdef RX_SYNC_STATS_EN
  logic [STAT_W-1:0] ok_cnt_q, lts_err_cnt_q, timeout_cnt_q;

  // Counters follow the registered pulses, so fail_code already names the cause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_cnt_q      <= '0;
      lts_err_cnt_q <= '0;
      timeout_cnt_q <= '0;
    end else if (stats_clr) begin
      ok_cnt_q      <= '0;
      lts_err_cnt_q <= '0;
      timeout_cnt_q <= '0;
    end else begin
      if (ok_q && (ok_cnt_q != '1)) ok_cnt_q <= ok_cnt_q + 1'b1;
      if (fail_q && (code_q == FailLtsErr) && (lts_err_cnt_q != '1)) begin
        lts_err_cnt_q <= lts_err_cnt_q + 1'b1;
      end
      if (fail_q && (code_q != FailLtsErr) && (timeout_cnt_q != '1)) begin
        timeout_cnt_q <= timeout_cnt_q + 1'b1;
      end
    end
  end

  assign ok_cnt      = ok_cnt_q;
  assign lts_err_cnt = lts_err_cnt_q;
  assign timeout_cnt = timeout_cnt_q;
`endif

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// Directed self-checking bench for rx_sync_ctrl (MAX_PKT reduced to 1000).
module tb_rx_sync_ctrl;
  localparam int unsigned DW    = 16;
  localparam int unsigned CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic sts_valid = 1'b0;
  logic lts_sv = 1'b0;
  logic lts_st = 1'b0;
  logic pkt_done = 1'b0;
  logic sts_en, lts_en, data_en, sync_ok, sync_fail;
  logic [2:0]       state;
  logic [CNT_W-1:0] sample_cnt;
  logic [1:0]       fail_code;
`ifdef RX_SYNC_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] ok_cnt, lts_err_cnt, timeout_cnt;
`endif

  int tests = 0;
  int failed = 0;
  int ok_seen = 0;
  int fail_seen = 0;
  int ov_seen = 0;
  logic [DW-1:0] din = '0;

  rx_sync_ctrl_if #(.DW(DW)) smp ();

  always #5 clk = ~clk;

  rx_sync_ctrl #(
    .DW(DW), .CNT_W(CNT_W), .LTS_TIMEOUT(320), .MAX_PKT(1000), .HOLDOFF(16)
  ) dut (
    .clk                          (clk),
    .rst                          (rst),
    .enable                       (enable),
    .smp                          (smp),
    .sts_coarse_freq_offset_valid (sts_valid),
    .detect_lts_status_valid      (lts_sv),
    .detect_lts_status            (lts_st),
    .pkt_done                     (pkt_done),
    .sts_detect_enable            (sts_en),
    .lts_detect_enable            (lts_en),
    .rx_data_enable               (data_en),
    .state_o                      (state),
    .sample_cnt                   (sample_cnt),
    .sync_ok                      (sync_ok),
    .sync_fail                    (sync_fail),
    .fail_code                    (fail_code)
`ifdef RX_SYNC_STATS_EN
    ,
    .stats_clr                    (stats_clr),
    .ok_cnt                       (ok_cnt),
    .lts_err_cnt                  (lts_err_cnt),
    .timeout_cnt                  (timeout_cnt)
`endif
  );

  // Pulse/valid monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (sync_ok === 1'b1) ok_seen++;
    if (sync_fail === 1'b1) fail_seen++;
    if (smp.sample_out_valid === 1'b1) ov_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samples(input int n);
    for (int k = 0; k < n; k++) begin
      din = din + 1'b1;
      smp.sample_in_i     = din;
      smp.sample_in_q     = ~din;
      smp.sample_in_valid = 1'b1;
      tick();
    end
    smp.sample_in_valid = 1'b0;
  endtask

  task automatic pulse_sts();
    sts_valid = 1'b1;
    tick();
    sts_valid = 1'b0;
  endtask

  task automatic pulse_status(input logic err);
    lts_sv = 1'b1;
    lts_st = err;
    tick();
    lts_sv = 1'b0;
    lts_st = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    tests++;
    if ({sts_en, lts_en, data_en, sync_ok, sync_fail, smp.sample_out_valid} !== 6'b0 ||
        state !== 3'd0 || sample_cnt !== '0 || fail_code !== 2'b00) begin
      failed++;
      $display("FAIL reset_values: state=%0d cnt=%0d code=%b en=%b%b%b ok=%b fail=%b ov=%b, want all 0",
               state, sample_cnt, fail_code, sts_en, lts_en, data_en, sync_ok, sync_fail,
               smp.sample_out_valid);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (state !== 3'd0) begin
      failed++;
      $display("FAIL idle_when_disabled: state=%0d want 0", state);
    end
    enable = 1'b1;
    tick();
    tests++;
    if (state !== 3'd1 || sts_en !== 1'b1) begin
      failed++;
      $display("FAIL arm_sts: state=%0d sts_en=%b want 1/1", state, sts_en);
    end
  endtask

  task automatic test_good_packet();
    int ok0 = ok_seen;
    int f0 = fail_seen;
    int ov0 = ov_seen;
    smp.sample_in_i = 16'sh1234;
    smp.sample_in_q = -16'sd5;
    tick();
    tests++;
    if (smp.sample_out_i !== 16'sh1234 || smp.sample_out_q !== -16'sd5 ||
        smp.sample_out_valid !== 1'b0) begin
      failed++;
      $display("FAIL sample_path_ungated: i=%h q=%h v=%b want 1234/fffb/0",
               smp.sample_out_i, smp.sample_out_q, smp.sample_out_valid);
    end
    pulse_sts();
    tests++;
    if (state !== 3'd2 || lts_en !== 1'b1 || sample_cnt !== '0) begin
      failed++;
      $display("FAIL sts_to_lts: state=%0d lts_en=%b cnt=%0d want 2/1/0", state, lts_en, sample_cnt);
    end
    samples(100);
    pulse_status(1'b0);
    tests++;
    if (state !== 3'd3 || sync_ok !== 1'b1 || data_en !== 1'b1 || sample_cnt !== 16'd100) begin
      failed++;
      $display("FAIL lts_ok: state=%0d ok=%b data_en=%b cnt=%0d want 3/1/1/100",
               state, sync_ok, data_en, sample_cnt);
    end
    samples(500);
    tests++;
    if (smp.sample_out_i !== din || smp.sample_out_valid !== 1'b1) begin
      failed++;
      $display("FAIL rx_sample_out: i=%h v=%b want %h/1", smp.sample_out_i, smp.sample_out_valid, din);
    end
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    tests++;
    if (state !== 3'd4 || sample_cnt !== 16'd600 || sync_fail !== 1'b0) begin
      failed++;
      $display("FAIL pkt_done: state=%0d cnt=%0d fail=%b want 4/600/0", state, sample_cnt, sync_fail);
    end
    samples(15);
    tests++;
    if (state !== 3'd4) begin
      failed++;
      $display("FAIL holdoff_15: state=%0d want 4", state);
    end
    samples(1);
    tests++;
    if (state !== 3'd1 || sample_cnt !== 16'd600) begin
      failed++;
      $display("FAIL holdoff_done: state=%0d cnt=%0d want 1/600", state, sample_cnt);
    end
    tests++;
    if (ok_seen - ok0 != 1 || fail_seen - f0 != 0 || ov_seen - ov0 != 500) begin
      failed++;
      $display("FAIL good_pkt_counts: ok=%0d fail=%0d ov=%0d want 1/0/500",
               ok_seen - ok0, fail_seen - f0, ov_seen - ov0);
    end
  endtask

  task automatic test_lts_timeout();
    int f0 = fail_seen;
    pulse_sts();
    samples(319);
    tests++;
    if (state !== 3'd2) begin
      failed++;
      $display("FAIL lts_before_timeout: state=%0d want 2", state);
    end
    samples(1);
    tests++;
    if (state !== 3'd4 || sync_fail !== 1'b1 || fail_code !== 2'b01 || sample_cnt !== 16'd320) begin
      failed++;
      $display("FAIL lts_timeout: state=%0d fail=%b code=%b cnt=%0d want 4/1/01/320",
               state, sync_fail, fail_code, sample_cnt);
    end
    samples(15);
    tests++;
    if (state !== 3'd4) begin
      failed++;
      $display("FAIL timeout_holdoff: state=%0d want 4", state);
    end
    samples(1);
    tests++;
    if (state !== 3'd1 || fail_seen - f0 != 1) begin
      failed++;
      $display("FAIL timeout_rearm: state=%0d fails=%0d want 1/1", state, fail_seen - f0);
    end
  endtask

  task automatic test_status_vs_timeout();
    pulse_sts();
    samples(319);
    din = din + 1'b1;
    smp.sample_in_i     = din;
    smp.sample_in_valid = 1'b1;
    lts_sv = 1'b1;
    lts_st = 1'b1;
    tick();
    smp.sample_in_valid = 1'b0;
    lts_sv = 1'b0;
    lts_st = 1'b0;
    tests++;
    if (state !== 3'd4 || sync_fail !== 1'b1 || fail_code !== 2'b10) begin
      failed++;
      $display("FAIL status_wins: state=%0d fail=%b code=%b want 4/1/10", state, sync_fail, fail_code);
    end
    samples(16);
  endtask

  task automatic test_overlength();
    int f0;
    pulse_sts();
    pulse_status(1'b0);
    samples(999);
    tests++;
    if (state !== 3'd3) begin
      failed++;
      $display("FAIL before_maxpkt: state=%0d want 3", state);
    end
    samples(1);
    tests++;
    if (state !== 3'd4 || sync_fail !== 1'b1 || fail_code !== 2'b11 || sample_cnt !== 16'd1000) begin
      failed++;
      $display("FAIL overlength: state=%0d fail=%b code=%b cnt=%0d want 4/1/11/1000",
               state, sync_fail, fail_code, sample_cnt);
    end
    samples(16);
    f0 = fail_seen;
    pulse_sts();
    pulse_status(1'b0);
    samples(999);
    din = din + 1'b1;
    smp.sample_in_i     = din;
    smp.sample_in_valid = 1'b1;
    pkt_done = 1'b1;
    tick();
    smp.sample_in_valid = 1'b0;
    pkt_done = 1'b0;
    tests++;
    if (state !== 3'd4 || sync_fail !== 1'b0 || fail_code !== 2'b11) begin
      failed++;
      $display("FAIL pkt_done_wins: state=%0d fail=%b code=%b want 4/0/11", state, sync_fail, fail_code);
    end
    samples(16);
    tests++;
    if (state !== 3'd1 || fail_seen - f0 != 0) begin
      failed++;
      $display("FAIL pkt_done_wins_rearm: state=%0d fails=%0d want 1/0", state, fail_seen - f0);
    end
  endtask

  task automatic test_enable_drop();
    int ok0 = ok_seen;
    int f0 = fail_seen;
    pulse_sts();
    pulse_status(1'b0);
    samples(50);
    smp.sample_in_valid = 1'b1;
    enable = 1'b0;
    tick();
    smp.sample_in_valid = 1'b0;
    tests++;
    if (state !== 3'd0 || sample_cnt !== '0 || smp.sample_out_valid !== 1'b0 ||
        sync_ok !== 1'b0 || sync_fail !== 1'b0 || fail_code !== 2'b11) begin
      failed++;
      $display("FAIL enable_drop: state=%0d cnt=%0d ov=%b ok=%b fail=%b code=%b want 0/0/0/0/0/11",
               state, sample_cnt, smp.sample_out_valid, sync_ok, sync_fail, fail_code);
    end
    enable = 1'b1;
    tick();
    tests++;
    if (state !== 3'd1 || ok_seen - ok0 != 1 || fail_seen - f0 != 0) begin
      failed++;
      $display("FAIL enable_restore: state=%0d ok=%0d fail=%0d want 1/1/0",
               state, ok_seen - ok0, fail_seen - f0);
    end
  endtask

  task automatic test_async_reset();
    pulse_sts();
    pulse_status(1'b0);
    samples(20);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (state !== 3'd0 || sample_cnt !== '0 || fail_code !== 2'b00 ||
        smp.sample_out_valid !== 1'b0 || smp.sample_out_i !== '0) begin
      failed++;
      $display("FAIL async_reset: state=%0d cnt=%0d code=%b ov=%b i=%h want 0/0/00/0/0",
               state, sample_cnt, fail_code, smp.sample_out_valid, smp.sample_out_i);
    end
    tick();
    rst = 1'b0;
    tick();
    tests++;
    if (state !== 3'd1) begin
      failed++;
      $display("FAIL after_async_reset: state=%0d want 1", state);
    end
  endtask

`ifdef RX_SYNC_STATS_EN
  task automatic test_stats();
    for (int p = 0; p < 3; p++) begin
      pulse_sts();
      pulse_status(1'b0);
      samples(10);
      pkt_done = 1'b1;
      tick();
      pkt_done = 1'b0;
      samples(16);
    end
    pulse_sts();
    pulse_status(1'b1);
    samples(16);
    tests++;
    if (ok_cnt !== 16'd3 || lts_err_cnt !== 16'd1 || timeout_cnt !== 16'd0) begin
      failed++;
      $display("FAIL stats_counts: ok=%0d lts=%0d to=%0d want 3/1/0", ok_cnt, lts_err_cnt, timeout_cnt);
    end
    pulse_sts();
    pulse_status(1'b0);
    tests++;
    if (sync_ok !== 1'b1) begin
      failed++;
      $display("FAIL stats_ok_pulse: ok=%b want 1", sync_ok);
    end
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    tests++;
    if (ok_cnt !== 16'd0 || lts_err_cnt !== 16'd0) begin
      failed++;
      $display("FAIL stats_clr_wins: ok=%0d lts=%0d want 0/0", ok_cnt, lts_err_cnt);
    end
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    samples(16);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want $finish before it");
    $fatal(1, "watchdog");
  end

  initial begin
    smp.sample_in_i     = '0;
    smp.sample_in_q     = '0;
    smp.sample_in_valid = 1'b0;
    test_reset();
    test_good_packet();
    test_lts_timeout();
    test_status_vs_timeout();
    test_overlength();
    test_enable_drop();
    test_async_reset();
`ifdef RX_SYNC_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
